// File: rtl/signed_display_if.sv
// Handshake and display bus between a value producer and signed_display_ctrl.
interface signed_display_if;
  logic       in_valid;
  logic [5:0] in_value;
  logic       in_ready;
  logic       busy;
  logic       done;
  logic       disp_neg;
  logic [3:0] disp_tens;
  logic [3:0] disp_ones;
  logic [2:0] seg_an;
  logic [3:0] seg_code;

  // Producer side: offers values and observes status/display.
  modport master (
    output in_valid, in_value,
    input  in_ready, busy, done, disp_neg, disp_tens, disp_ones, seg_an, seg_code
  );

  // Controller side.
  modport slave (
    input  in_valid, in_value,
    output in_ready, busy, done, disp_neg, disp_tens, disp_ones, seg_an, seg_code
  );
endinterface

// File: rtl/signed_display_ctrl.sv
// Signed 6-bit value to sign/tens/ones converter with a multiplexed 3-digit scan.
module signed_display_ctrl #(
  parameter int unsigned SCAN_DIV = 16
) (
  input  logic            clk,
  input  logic            resetn,
  signed_display_if.slave bus
);

  localparam int unsigned VAL_W = 6;
  localparam int unsigned DIG_W = 4;
  localparam int unsigned AN_W  = 3;
  localparam int unsigned IDX_W = 2;
  localparam int unsigned CNT_W = (SCAN_DIV > 1) ? $clog2(SCAN_DIV) : 1;

  localparam logic [DIG_W-1:0] CODE_MINUS = 4'hA;
  localparam logic [DIG_W-1:0] CODE_BLANK = 4'hF;

  typedef enum logic [1:0] {
    ST_IDLE,
    ST_CONV,
    ST_BCD,
    ST_DONE
  } state_t;

  state_t             state_q;
  logic [VAL_W-1:0]   val_q;
  logic               neg_q;
  logic [VAL_W-1:0]   rem_q;
  logic [DIG_W-1:0]   tens_q;
  logic               in_ready_q;
  logic               busy_q;
  logic               done_q;
  logic               disp_neg_q;
  logic [DIG_W-1:0]   disp_tens_q;
  logic [DIG_W-1:0]   disp_ones_q;

  logic [CNT_W-1:0]   cnt_q;
  logic [IDX_W-1:0]   idx_q;
  logic [IDX_W-1:0]   idx_d;
  logic [AN_W-1:0]    seg_an_q;
  logic [AN_W-1:0]    seg_an_d;
  logic [DIG_W-1:0]   seg_code_q;
  logic [DIG_W-1:0]   seg_code_d;

  logic [VAL_W-1:0]   mag_c;

  // Magnitude of the captured value; -32 wraps to 6'd32 which is the correct magnitude.
  assign mag_c = val_q[VAL_W-1] ? VAL_W'(~val_q + VAL_W'(1)) : val_q;

  // Conversion sequencer: capture, sign split, serial subtract-10, latch display.
  always_ff @(posedge clk) begin
    if (!resetn) begin
      state_q     <= ST_IDLE;
      val_q       <= '0;
      neg_q       <= 1'b0;
      rem_q       <= '0;
      tens_q      <= '0;
      in_ready_q  <= 1'b1;
      busy_q      <= 1'b0;
      done_q      <= 1'b0;
      disp_neg_q  <= 1'b0;
      disp_tens_q <= '0;
      disp_ones_q <= '0;
    end else begin
      done_q <= 1'b0;
      case (state_q)
        ST_IDLE: begin
          if (bus.in_valid) begin
            val_q      <= bus.in_value;
            state_q    <= ST_CONV;
            in_ready_q <= 1'b0;
            busy_q     <= 1'b1;
          end
        end
        ST_CONV: begin
          neg_q   <= val_q[VAL_W-1];
          rem_q   <= mag_c;
          tens_q  <= '0;
          state_q <= ST_BCD;
        end
        ST_BCD: begin
          if (rem_q >= VAL_W'(10)) begin
            rem_q  <= rem_q - VAL_W'(10);
            tens_q <= tens_q + DIG_W'(1);
          end else begin
            disp_neg_q  <= neg_q;
            disp_tens_q <= tens_q;
            disp_ones_q <= rem_q[DIG_W-1:0];
            done_q      <= 1'b1;
            state_q     <= ST_DONE;
          end
        end
        ST_DONE: begin
          state_q    <= ST_IDLE;
          in_ready_q <= 1'b1;
          busy_q     <= 1'b0;
        end
        default: begin
          state_q    <= ST_IDLE;
          in_ready_q <= 1'b1;
          busy_q     <= 1'b0;
        end
      endcase
    end
  end

  // Next digit to show and its anode/code, selected from the latched display registers.
  always_comb begin
    idx_d      = (idx_q == IDX_W'(2)) ? IDX_W'(0) : idx_q + IDX_W'(1);
    seg_an_d   = 3'b110;
    seg_code_d = disp_ones_q;
    case (idx_d)
      IDX_W'(0): begin
        seg_an_d   = 3'b110;
        seg_code_d = disp_ones_q;
      end
      IDX_W'(1): begin
        seg_an_d   = 3'b101;
        seg_code_d = (disp_tens_q == '0) ? CODE_BLANK : disp_tens_q;
      end
      IDX_W'(2): begin
        seg_an_d   = 3'b011;
        seg_code_d = disp_neg_q ? CODE_MINUS : CODE_BLANK;
      end
      default: begin
        seg_an_d   = 3'b110;
        seg_code_d = disp_ones_q;
      end
    endcase
  end

  // Free-running scan divider; anode and code advance together on wrap.
  always_ff @(posedge clk) begin
    if (!resetn) begin
      cnt_q      <= '0;
      idx_q      <= '0;
      seg_an_q   <= 3'b110;
      seg_code_q <= '0;
    end else if (cnt_q == CNT_W'(SCAN_DIV - 1)) begin
      cnt_q      <= '0;
      idx_q      <= idx_d;
      seg_an_q   <= seg_an_d;
      seg_code_q <= seg_code_d;
    end else begin
      cnt_q <= cnt_q + CNT_W'(1);
    end
  end

  assign bus.in_ready  = in_ready_q;
  assign bus.busy      = busy_q;
  assign bus.done      = done_q;
  assign bus.disp_neg  = disp_neg_q;
  assign bus.disp_tens = disp_tens_q;
  assign bus.disp_ones = disp_ones_q;
  assign bus.seg_an    = seg_an_q;
  assign bus.seg_code  = seg_code_q;

endmodule
